branch_predict_resolve: RTL and testbench

Parametrised branch unit for the RV32 pipeline. It combines a fetch-stage direction predictor with execute-stage branch resolution. The predictor is a direct-mapped table of saturating counters indexed by PC, read with one-cycle latency. The execute stage evaluates the branch condition for JAL and all six conditional branches, trains the table, raises a registered mispredict/flush pulse, and keeps saturating performance counters.

---
 rtl/riscv_branch_pkg.sv | 19 +
 rtl/branch_compare.sv | 31 +++
 rtl/branch_predict_resolve.sv | 127 ++++++++++++
 tb/tb_branch_predict_resolve.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_branch_pkg.sv
// Shared RV32 branch encodings: opcode[6:2] values and conditional-branch funct3 codes.
package riscv_branch_pkg;

  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // funct3 010/011 are not branches, so they neither train nor count
  function automatic logic is_cond_funct3(input logic [2:0] funct3);
    return (funct3 != 3'b010) && (funct3 != 3'b011);
  endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation for JAL and the six conditional branches.
module branch_compare
  import riscv_branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    if (opcode == OPC_JAL) begin
      taken = 1'b1;
    end else if (opcode == OPC_BRANCH) begin
      case (funct3)
        BEQ:     taken = (rs1 == rs2);
        BNE:     taken = (rs1 != rs2);
        BLT:     taken = ($signed(rs1) <  $signed(rs2));
        BGE:     taken = ($signed(rs1) >= $signed(rs2));
        BLTU:    taken = (rs1 <  rs2);
        BGEU:    taken = (rs1 >= rs2);
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Fetch-stage saturating-counter direction predictor combined with execute-stage
// branch resolution, table training, mispredict flush pulse and performance counters.
module branch_predict_resolve
  import riscv_branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int PC_LSB      = 2
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            lookup_valid_in,
  input  logic [XLEN-1:0] lookup_pc_in,
  output logic            predict_valid_out,
  output logic            predict_taken_out,
  input  logic            ex_valid_in,
  input  logic [XLEN-1:0] ex_pc_in,
  input  logic [4:0]      opcode_6_to_2_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic            ex_pred_taken_in,
  output logic            branch_taken_out,
  output logic            mispredict_out,
  output logic [31:0]     branch_count_out,
  output logic [31:0]     mispredict_count_out
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [31:0]         CNT_MAX  = 32'hFFFF_FFFF;
  localparam logic [31:0]         CNT_ONE  = 32'd1;

  logic [CTR_BITS-1:0] bht [BHT_ENTRIES];

  logic [IDX_W-1:0]    lookup_idx;
  logic [IDX_W-1:0]    update_idx;
  logic [CTR_BITS-1:0] update_cur;
  logic [CTR_BITS-1:0] update_next;
  logic                cmp_taken;
  logic                resolved_taken;
  logic                is_update;
  logic                is_jal;
  logic                mismatch;

  logic                predict_valid_q;
  logic                predict_taken_q;
  logic                mispredict_q;
  logic [31:0]         branch_cnt;
  logic [31:0]         mispredict_cnt;

  logic                unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc_in, ex_pc_in};

  assign lookup_idx = lookup_pc_in[PC_LSB +: IDX_W];
  assign update_idx = ex_pc_in[PC_LSB +: IDX_W];

  branch_compare #(
    .XLEN (XLEN)
  ) u_compare (
    .opcode (opcode_6_to_2_in),
    .funct3 (funct3_in),
    .rs1    (rs1_in),
    .rs2    (rs2_in),
    .taken  (cmp_taken)
  );

  assign resolved_taken = ex_valid_in & cmp_taken;
  assign is_update      = ex_valid_in && (opcode_6_to_2_in == OPC_BRANCH)
                          && is_cond_funct3(funct3_in);
  assign is_jal         = ex_valid_in && (opcode_6_to_2_in == OPC_JAL);
  assign mismatch       = (is_update || is_jal) && (resolved_taken != ex_pred_taken_in);

  always_comb begin
    update_cur  = bht[update_idx];
    update_next = update_cur;
    if (resolved_taken) begin
      if (update_cur != CTR_MAX) update_next = update_cur + CTR_ONE;
    end else begin
      if (update_cur != '0) update_next = update_cur - CTR_ONE;
    end
  end

  // Register array rather than a RAM so reset can clear every entry at once
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
    end else if (is_update) begin
      bht[update_idx] <= update_next;
    end
  end

  // Read sees the pre-update entry when lookup and update collide
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      predict_valid_q <= 1'b0;
      predict_taken_q <= 1'b0;
    end else begin
      predict_valid_q <= lookup_valid_in;
      if (lookup_valid_in) predict_taken_q <= bht[lookup_idx][CTR_BITS-1];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mispredict_q   <= 1'b0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      mispredict_q <= mismatch;
      if (is_update && branch_cnt != CNT_MAX) branch_cnt <= branch_cnt + CNT_ONE;
      if (mismatch && mispredict_cnt != CNT_MAX) mispredict_cnt <= mispredict_cnt + CNT_ONE;
    end
  end

  assign predict_valid_out    = predict_valid_q;
  assign predict_taken_out    = predict_taken_q;
  assign branch_taken_out     = resolved_taken;
  assign mispredict_out       = mispredict_q;
  assign branch_count_out     = branch_cnt;
  assign mispredict_count_out = mispredict_cnt;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed scoreboard bench for branch_predict_resolve: expected values are queued
// when stimulus is driven and popped when the corresponding output is sampled.
module tb_branch_predict_resolve;
  import riscv_branch_pkg::*;

  logic        clk_in;
  logic        rst_n_in;
  logic        lookup_valid_in;
  logic [31:0] lookup_pc_in;
  logic        predict_valid_out;
  logic        predict_taken_out;
  logic        ex_valid_in;
  logic [31:0] ex_pc_in;
  logic [4:0]  opcode_6_to_2_in;
  logic [2:0]  funct3_in;
  logic [31:0] rs1_in;
  logic [31:0] rs2_in;
  logic        ex_pred_taken_in;
  logic        branch_taken_out;
  logic        mispredict_out;
  logic [31:0] branch_count_out;
  logic [31:0] mispredict_count_out;

  int          checks = 0;
  int          errors = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  branch_predict_resolve dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
    .lookup_valid_in      (lookup_valid_in),
    .lookup_pc_in         (lookup_pc_in),
    .predict_valid_out    (predict_valid_out),
    .predict_taken_out    (predict_taken_out),
    .ex_valid_in          (ex_valid_in),
    .ex_pc_in             (ex_pc_in),
    .opcode_6_to_2_in     (opcode_6_to_2_in),
    .funct3_in            (funct3_in),
    .rs1_in               (rs1_in),
    .rs2_in               (rs2_in),
    .ex_pred_taken_in     (ex_pred_taken_in),
    .branch_taken_out     (branch_taken_out),
    .mispredict_out       (mispredict_out),
    .branch_count_out     (branch_count_out),
    .mispredict_count_out (mispredict_count_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic expect_val(input string tag, input logic [31:0] value);
    tag_q.push_back(tag);
    exp_q.push_back(value);
  endtask

  task automatic check_output(input logic [31:0] observed);
    string       tag;
    logic [31:0] expected;
    tag      = tag_q.pop_front();
    expected = exp_q.pop_front();
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [31:0] pc, input logic [4:0] opc,
                                input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic pred);
    ex_valid_in      = valid;
    ex_pc_in         = pc;
    opcode_6_to_2_in = opc;
    funct3_in        = f3;
    rs1_in           = a;
    rs2_in           = b;
    ex_pred_taken_in = pred;
  endtask

  task automatic ex_idle();
    apply_stimulus(1'b0, 32'h0, 5'b00000, 3'b000, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic set_lookup(input logic valid, input logic [31:0] pc);
    lookup_valid_in = valid;
    lookup_pc_in    = pc;
  endtask

  task automatic step();
    @(negedge clk_in);
  endtask

  // Lookup alone for one cycle and compare the returned direction
  task automatic lookup_check(input string tag, input logic [31:0] pc, input logic exp_taken);
    set_lookup(1'b1, pc);
    expect_val(tag, {31'b0, exp_taken});
    step();
    check_output({31'b0, predict_taken_out});
    set_lookup(1'b0, 32'h0);
  endtask

  task automatic counters_check(input string tag, input logic [31:0] exp_b, input logic [31:0] exp_m);
    expect_val({tag, "_bcnt"}, exp_b);
    expect_val({tag, "_mcnt"}, exp_m);
    check_output(branch_count_out);
    check_output(mispredict_count_out);
  endtask

  task automatic all_zero_check(input string tag);
    expect_val({tag, "_pv"}, 32'h0);
    expect_val({tag, "_pt"}, 32'h0);
    expect_val({tag, "_mp"}, 32'h0);
    expect_val({tag, "_bcnt"}, 32'h0);
    expect_val({tag, "_mcnt"}, 32'h0);
    check_output({31'b0, predict_valid_out});
    check_output({31'b0, predict_taken_out});
    check_output({31'b0, mispredict_out});
    check_output(branch_count_out);
    check_output(mispredict_count_out);
  endtask

  initial begin
    rst_n_in = 1'b0;
    set_lookup(1'b0, 32'h0);
    ex_idle();
    repeat (2) step();
    all_zero_check("reset");
    rst_n_in = 1'b1;
    step();

    // First lookup after reset sees weakly-not-taken
    set_lookup(1'b1, 32'h100);
    expect_val("first_pv", 32'h1);
    expect_val("first_pt", 32'h0);
    step();
    check_output({31'b0, predict_valid_out});
    check_output({31'b0, predict_taken_out});
    set_lookup(1'b0, 32'h0);

    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b1, 32'h100, OPC_BRANCH, BEQ, 32'd5, 32'd5, 1'b1);
      expect_val("beq_taken", 32'h1);
      #1 check_output({31'b0, branch_taken_out});
      step();
    end
    ex_idle();
    expect_val("beq_no_mp", 32'h0);
    check_output({31'b0, mispredict_out});
    counters_check("beq2", 32'd2, 32'd0);
    lookup_check("pt_after_2_taken", 32'h100, 1'b1);

    // Third taken must saturate at 3, so a single not-taken leaves MSB set
    apply_stimulus(1'b1, 32'h100, OPC_BRANCH, BEQ, 32'd5, 32'd5, 1'b1);
    step();
    apply_stimulus(1'b1, 32'h100, OPC_BRANCH, BNE, 32'd5, 32'd5, 1'b0);
    expect_val("bne_not_taken", 32'h0);
    #1 check_output({31'b0, branch_taken_out});
    step();
    ex_idle();
    lookup_check("pt_after_saturate", 32'h100, 1'b1);
    counters_check("beq3_bne", 32'd4, 32'd0);

    apply_stimulus(1'b1, 32'h204, OPC_BRANCH, BLT, 32'hFFFF_FFFF, 32'd1, 1'b1);
    expect_val("blt_signed", 32'h1);
    #1 check_output({31'b0, branch_taken_out});
    step();
    apply_stimulus(1'b1, 32'h204, OPC_BRANCH, BLTU, 32'hFFFF_FFFF, 32'd1, 1'b1);
    expect_val("bltu_unsigned", 32'h0);
    #1 check_output({31'b0, branch_taken_out});
    step();
    ex_idle();
    expect_val("bltu_mp_pulse", 32'h1);
    check_output({31'b0, mispredict_out});
    counters_check("bltu", 32'd6, 32'd1);
    step();
    expect_val("bltu_mp_clear", 32'h0);
    check_output({31'b0, mispredict_out});

    // Same-index lookup and update: read-before-write
    set_lookup(1'b1, 32'h14);
    apply_stimulus(1'b1, 32'h14, OPC_BRANCH, BGEU, 32'd2, 32'd1, 1'b1);
    expect_val("rbw_old", 32'h0);
    step();
    check_output({31'b0, predict_taken_out});
    ex_idle();
    set_lookup(1'b0, 32'h0);
    lookup_check("rbw_new", 32'h14, 1'b1);

    // Different-index lookup and update in the same cycle
    set_lookup(1'b1, 32'h100);
    apply_stimulus(1'b1, 32'h18, OPC_BRANCH, BGE, 32'hFFFF_FFFF, 32'd0, 1'b0);
    expect_val("bge_signed_nt", 32'h0);
    expect_val("diff_idx_lookup", 32'h1);
    #1 check_output({31'b0, branch_taken_out});
    step();
    check_output({31'b0, predict_taken_out});
    ex_idle();
    set_lookup(1'b0, 32'h0);
    counters_check("diff_idx", 32'd8, 32'd1);

    apply_stimulus(1'b0, 32'h100, OPC_BRANCH, BEQ, 32'd7, 32'd7, 1'b0);
    expect_val("invalid_forced_nt", 32'h0);
    #1 check_output({31'b0, branch_taken_out});
    step();
    apply_stimulus(1'b1, 32'h100, OPC_BRANCH, 3'b010, 32'd7, 32'd7, 1'b0);
    expect_val("funct3_010_nt", 32'h0);
    #1 check_output({31'b0, branch_taken_out});
    step();
    ex_idle();
    counters_check("non_updates", 32'd8, 32'd1);

    // JAL resolves taken, flushes, but neither trains nor counts as a branch
    apply_stimulus(1'b1, 32'h1C, OPC_JAL, 3'b000, 32'd0, 32'd0, 1'b0);
    expect_val("jal_taken", 32'h1);
    #1 check_output({31'b0, branch_taken_out});
    step();
    ex_idle();
    expect_val("jal_mp", 32'h1);
    check_output({31'b0, mispredict_out});
    counters_check("jal", 32'd8, 32'd2);
    lookup_check("jal_no_train", 32'h1C, 1'b0);

    step();
    force dut.branch_cnt = 32'hFFFF_FFFE;
    #1 release dut.branch_cnt;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'h40, OPC_BRANCH, BEQ, 32'd3, 32'd3, 1'b1);
      step();
    end
    ex_idle();
    counters_check("bcnt_saturate", 32'hFFFF_FFFF, 32'd2);

    // Mid-stream asynchronous reset with outputs active
    set_lookup(1'b1, 32'h40);
    apply_stimulus(1'b1, 32'h40, OPC_BRANCH, BEQ, 32'd1, 32'd2, 1'b1);
    expect_val("pre_reset_mp", 32'h1);
    expect_val("pre_reset_pt", 32'h1);
    step();
    check_output({31'b0, mispredict_out});
    check_output({31'b0, predict_taken_out});
    #2 rst_n_in = 1'b0;
    #1 all_zero_check("async_reset");
    set_lookup(1'b0, 32'h0);
    ex_idle();
    step();
    rst_n_in = 1'b1;
    step();
    lookup_check("reset_tbl_100", 32'h100, 1'b0);
    lookup_check("reset_tbl_40", 32'h40, 1'b0);
    lookup_check("reset_tbl_14", 32'h14, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
